// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: responder side of the instruction-fetch interface, holding the instruction array.
// Latency: valid_o pulses exactly LATENCY+1 cycles after the accept cycle (LATENCY wait-states, 0..15).
// Backpressure: ready_o is low only during wait-states; flush_i forces ready_o high and drops the outstanding fetch.
//
// Optional feature: define IMEM_FETCH_CNT_EN to add fetch_cnt_o, a wrapping count of delivered responses.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_i, addr_i, ready_o      fetch request handshake; addr_i is a byte address sampled on accept
//   valid_o, instr_o, misalign_o single-cycle response; instr_o/misalign_o hold between responses
//   flush_i                     branch redirect: cancels the outstanding fetch, may carry a new request
//   load_en_i, load_addr_i, load_data_i  array write port, usable in any state
//   fetch_cnt_o                 (IMEM_FETCH_CNT_EN only) number of delivered responses
module imem_fetch_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
`ifdef IMEM_FETCH_CNT_EN
    output logic [31:0] fetch_cnt_o,
`endif
    input  logic        req_i,
    input  logic [31:0] addr_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic        misalign_o,
    input  logic        flush_i,
    input  logic        load_en_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_data_i
);

    // Word-index width; byte address bits [AW+1:2] select the word.
    localparam int AW = $clog2(DEPTH_WORDS);

    // Counter load value on accept; LATENCY==0 never enters WAIT.
    localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic [31:0] cap_addr;
    logic [31:0] cap_instr;
    logic        cap_misalign;

    // Only the word-index bits of the load address matter.
    logic        load_addr_unused;
    assign load_addr_unused = ^{load_addr_i[31:AW+2], load_addr_i[1:0]};

    // Handshake outputs are decoded from state; flush_i is the only input
    // that reaches them, so a redirect can always launch a new fetch.
    assign ready_o = (state != WAIT) || flush_i;
    assign valid_o = (state == RESP) && !flush_i;
    assign accept  = req_i && ready_o;

    // Response formation. With LATENCY==0 the capture happens on the accept
    // edge itself, so the incoming address is used; otherwise the capture
    // comes from WAIT, where accept is only possible together with a flush
    // that abandons this capture anyway.
    always_comb begin
        cap_addr     = accept ? addr_i : addr_q;
        cap_instr    = 32'h0000_0000;
        cap_misalign = 1'b0;
        if (cap_addr[1:0] != 2'b00) begin
            cap_misalign = 1'b1;
        end else if (cap_addr[31:AW+2] == '0) begin
            cap_instr = mem[cap_addr[AW+1:2]];
        end
    end

    // Instruction array. The non-blocking write means a capture on the same
    // edge as a write to the same word sees the old contents. Reset does not
    // touch the array so boot images survive a core reset.
    always_ff @(posedge clk) begin
        if (load_en_i) begin
            mem[load_addr_i[AW+1:2]] <= load_data_i;
        end
    end

    // Fetch FSM. A new accept outranks everything (back-to-back from RESP,
    // or a redirect fetch during flush); a bare flush returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            addr_q     <= 32'h0000_0000;
            instr_o    <= 32'h0000_0000;
            misalign_o <= 1'b0;
        end else if (accept) begin
            addr_q <= addr_i;
            if (LATENCY == 0) begin
                state      <= RESP;
                cnt        <= 4'd0;
                instr_o    <= cap_instr;
                misalign_o <= cap_misalign;
            end else begin
                state <= WAIT;
                cnt   <= CNT_INIT;
            end
        end else if (flush_i) begin
            state <= IDLE;
        end else begin
            case (state)
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state      <= RESP;
                        instr_o    <= cap_instr;
                        misalign_o <= cap_misalign;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IMEM_FETCH_CNT_EN
    // valid_o already excludes flushed responses, so they are never counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_o <= 32'h0000_0000;
        end else if (valid_o) begin
            fetch_cnt_o <= fetch_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb_imem_fetch_responder: randomized bench with a transaction-level reference model and scoreboard.
// The driver steps the model once per cycle and queues expected responses; a monitor checks the DUT.
// Configured for DEPTH_WORDS=256, LATENCY=2.
module tb_imem_fetch_responder;

    localparam int DEPTH = 256;
    localparam int L     = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [31:0] addr = 32'h0;
    logic        flush = 1'b0;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = 32'h0;
    logic [31:0] load_data = 32'h0;
    logic        ready;
    logic        valid;
    logic [31:0] instr;
    logic        misalign;
`ifdef IMEM_FETCH_CNT_EN
    logic [31:0] fetch_cnt;
`endif

    imem_fetch_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(L)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef IMEM_FETCH_CNT_EN
        .fetch_cnt_o (fetch_cnt),
`endif
        .req_i       (req),
        .addr_i      (addr),
        .ready_o     (ready),
        .valid_o     (valid),
        .instr_o     (instr),
        .misalign_o  (misalign),
        .flush_i     (flush),
        .load_en_i   (load_en),
        .load_addr_i (load_addr),
        .load_data_i (load_data)
    );

    typedef struct {
        logic [31:0] instr;
        logic        mis;
        int          due;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;

    // Reference model state: shadow array plus at most one outstanding fetch
    // described by its accept cycle and address.
    logic [31:0] mem_m [DEPTH];
    bit          have = 1'b0;
    bit          captured = 1'b0;
    int          acc = 0;
    logic [31:0] a_addr = 32'h0;
    int          n = 0;
    bit          mon_en = 1'b0;
    bit          exp_ready = 1'b1;
    logic [31:0] hold_instr = 32'h0;
    logic        hold_mis = 1'b0;
    logic [31:0] cur_hold_instr = 32'h0;
    logic        cur_hold_mis = 1'b0;
    int unsigned fcnt = 0;
    int unsigned cur_fcnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, n);
        end
    endtask

    function automatic void model_resp(input logic [31:0] a, output logic [31:0] ins, output logic mis);
        ins = 32'h0;
        mis = 1'b0;
        if (a[1:0] != 2'b00) mis = 1'b1;
        else if (a[31:10] == 22'd0) ins = mem_m[a[9:2]];
    endfunction

    // Response content is fixed by the array contents at the capture edge,
    // before any write on that same edge.
    function automatic void do_capture(input logic [31:0] a);
        exp_t e;
        model_resp(a, e.instr, e.mis);
        e.due = n + 1;
        q.push_back(e);
        hold_instr = e.instr;
        hold_mis   = e.mis;
        captured   = 1'b1;
    endfunction

    // Drive one cycle and advance the model across the edge that ends it.
    task automatic cyc(input bit r, input bit rq, input logic [31:0] ad, input bit fl,
                       input bit le, input logic [31:0] la, input logic [31:0] ld);
        bit vld;
        @(posedge clk);
        #1;
        rst = r; req = rq; addr = ad; flush = fl;
        load_en = le; load_addr = la; load_data = ld;
        n++;
        exp_ready      = fl || !(have && n <= acc + L);
        vld            = have && (n == acc + L + 1) && !fl;
        cur_hold_instr = hold_instr;
        cur_hold_mis   = hold_mis;
        cur_fcnt       = fcnt;
        if (fl && have) begin
            if (captured) void'(q.pop_back());
            have = 1'b0;
        end else if (vld) begin
            have = 1'b0;
        end
        if (vld) fcnt++;
        if (r) begin
            have = 1'b0; fcnt = 0; hold_instr = 32'h0; hold_mis = 1'b0;
        end else begin
            if (have && n == acc + L) do_capture(a_addr);
            if (rq && exp_ready) begin
                have = 1'b1; acc = n; a_addr = ad; captured = 1'b0;
                if (L == 0) do_capture(ad);
            end
        end
        if (le) mem_m[la[9:2]] = ld;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic fetch(input logic [31:0] a);
        cyc(1'b0, 1'b1, a, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, a, d);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: a = 32'($urandom_range(0, 15)) << 2;
            6:       a = 32'($urandom_range(0, 255)) << 2;
            7:       a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
            8:       a = ($urandom | 32'h0000_0400) & 32'hFFFF_FFFC;
            default: a = 32'h0000_0400;
        endcase
        return a;
    endfunction

    // Monitor: every cycle checks ready_o; on valid_o pops and compares the
    // oldest expected response, otherwise checks held outputs and flags a
    // response that was due but never appeared.
    always @(negedge clk) begin
        if (mon_en) begin
            check("ready", ready, exp_ready);
            if (valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got valid=1 expected valid=0 (cycle %0d)", n);
                end else begin
                    mon_e = q.pop_front();
                    check("resp_cycle", n, mon_e.due);
                    check("instr", instr, mon_e.instr);
                    check("misalign", misalign, mon_e.mis);
                end
            end else begin
                if (q.size() != 0 && q[0].due <= n) begin
                    mon_e = q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missing_valid: got valid=0 expected valid=1 due cycle %0d (cycle %0d)", mon_e.due, n);
                end
                check("hold_instr", instr, cur_hold_instr);
                check("hold_misalign", misalign, cur_hold_mis);
            end
`ifdef IMEM_FETCH_CNT_EN
            check("fetch_cnt", fetch_cnt, cur_fcnt);
`endif
        end
    end

    initial begin
        bit r, rq, fl, le;
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(1);
        mon_en = 1'b1;

        // Fill the whole array so every in-range fetch has defined data.
        for (int i = 0; i < DEPTH; i++) load(32'(i) << 2, $urandom);
        load(32'h0000_0000, 32'h2008_0005);
        load(32'h0000_0004, 32'h0109_5020);
        load(32'h0000_0008, 32'h0000_0000);
        load(32'h0000_0040, 32'h1000_FFFF);

        // Single fetch.
        fetch(32'h0000_0000);
        idle(4);
        // Request held through WAIT, next address taken in the RESP cycle.
        fetch(32'h0000_0004);
        fetch(32'h0000_0004);
        fetch(32'h0000_0004);
        fetch(32'h0000_0008);
        idle(4);
        // Misaligned and out-of-range.
        fetch(32'h0000_0002);
        idle(4);
        fetch(32'h0000_0400);
        idle(4);
        // Redirect one cycle after accept.
        fetch(32'h0000_0000);
        cyc(1'b0, 1'b1, 32'h0000_0040, 1'b1, 1'b0, 32'h0, 32'h0);
        idle(5);
        // Reset during WAIT, then confirm the array survived.
        fetch(32'h0000_0004);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(4);
        fetch(32'h0000_0040);
        idle(4);
        // Write colliding with the capture edge of the same word.
        fetch(32'h0000_0010);
        idle(1);
        load(32'h0000_0010, 32'hDEAD_BEEF);
        idle(3);

        // Randomized traffic with concurrent loads, flushes and resets.
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 99) == 0);
            rq = ($urandom_range(0, 99) < 60);
            fl = ($urandom_range(0, 99) < 8);
            le = ($urandom_range(0, 99) < 20);
            cyc(r, rq, rand_addr(), fl, le, 32'($urandom_range(0, 15)) << 2, $urandom);
        end
        idle(6);
        @(posedge clk);
        #1;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
